// File: rtl/mem_responder.sv
// mem_responder: line-organised backing store serving icache reads and dcache reads/writebacks with fixed latency; ports clk/reset, ic_req/ic_addr->ic_ack/ic_rdata, dc_req/dc_we/dc_addr/dc_wdata->dc_ack/dc_rdata, busy
module mem_responder #(
  parameter int LINE_W  = 128,
  parameter int IDX_W   = 10,
  parameter int LATENCY = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ic_req,
  input  logic [31:0]       ic_addr,
  output logic              ic_ack,
  output logic [LINE_W-1:0] ic_rdata,
  input  logic              dc_req,
  input  logic              dc_we,
  input  logic [31:0]       dc_addr,
  input  logic [LINE_W-1:0] dc_wdata,
  output logic              dc_ack,
  output logic [LINE_W-1:0] dc_rdata,
  output logic              busy
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic port_q, port_d, we_q, we_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [LINE_W-1:0] wdata_q, wdata_d, ic_rdata_q, ic_rdata_d, dc_rdata_q, dc_rdata_d, rd;
  logic ic_ack_q, ic_ack_d, dc_ack_q, dc_ack_d, busy_q, busy_d;
  logic gnt_dc, accept, done;
  logic [LINE_W-1:0] mem [2**IDX_W];
  logic unused_addr_bits;
  assign unused_addr_bits = ^{ic_addr[31:IDX_W+4], ic_addr[3:0], dc_addr[31:IDX_W+4], dc_addr[3:0]};
  always_comb begin
    gnt_dc     = dc_req && (!ic_req || !port_q);
    accept     = state_q == IDLE && (ic_req || dc_req);
    done       = state_q == WAIT && cnt_q == 4'd0;
    rd         = we_q ? wdata_q : mem[idx_q];
    state_d    = accept ? WAIT : done ? RESP : state_q == RESP ? IDLE : state_q;
    cnt_d      = accept ? 4'(LATENCY - 1) : (state_q == WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
    port_d     = accept ? gnt_dc : port_q;
    we_d       = accept ? gnt_dc && dc_we : we_q;
    idx_d      = accept ? (gnt_dc ? dc_addr[IDX_W+3:4] : ic_addr[IDX_W+3:4]) : idx_q;
    wdata_d    = accept && gnt_dc ? dc_wdata : wdata_q;
    ic_ack_d   = done && !port_q;
    dc_ack_d   = done && port_q;
    ic_rdata_d = ic_ack_d ? rd : ic_rdata_q;
    dc_rdata_d = dc_ack_d ? rd : dc_rdata_q;
    busy_d     = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      port_q     <= 1'b0;
      we_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      ic_ack_q   <= 1'b0;
      dc_ack_q   <= 1'b0;
      ic_rdata_q <= '0;
      dc_rdata_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      port_q     <= port_d;
      we_q       <= we_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      ic_ack_q   <= ic_ack_d;
      dc_ack_q   <= dc_ack_d;
      ic_rdata_q <= ic_rdata_d;
      dc_rdata_q <= dc_rdata_d;
      busy_q     <= busy_d;
    end
  end
  always_ff @(posedge clk)
    if (done && we_q) mem[idx_q] <= wdata_q;
  assign ic_ack   = ic_ack_q;
  assign dc_ack   = dc_ack_q;
  assign ic_rdata = ic_rdata_q;
  assign dc_rdata = dc_rdata_q;
  assign busy     = busy_q;
endmodule
